cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Drains the per-functional-unit result FIFOs (ALU, MUL, LSU, BRANCH) and broadcasts one result per cycle on the common data bus (CDB).
- Consumers are the reservation stations, the ROB and the register-status table.
- Acts as the reader side of the result-FIFO interface: it issues pops, captures the popped entry and drives it onto the CDB with round-robin fairness.

Parameters:
- N_SRC, 4, number of result FIFOs arbitrated (index 0 = ALU, 1 = MUL, 2 = LSU, 3 = BRANCH).
- PTR_W, $clog2(N_SRC), width of the round-robin pointer and grant index.

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk.
- en_i  in  1  global enable; when low, no pops are issued and stage state holds.
- flush_i  in  1  mispredict flush; kills the in-flight pop and the broadcast register.
- src_empty_i  in  N_SRC  per-FIFO empty flag.
- src_rd_o  out  N_SRC  per-FIFO pop strobe, one-hot or zero.
- src_data_i  in  N_SRC x cdb_struct_t  per-FIFO registered read data, valid one cycle after the pop.
- cdb_valid_o  out  1  CDB broadcast valid.
- cdb_data_o  out  cdb_struct_t  broadcast payload (tag, value, exception bits).
- cdb_src_o  out  PTR_W  index of the source that produced the current broadcast.

Behaviour:
- Reset (rst_n = 0 at posedge):
  - src_rd_o = 0, cdb_valid_o = 0, cdb_data_o = 0, cdb_src_o = 0.
  - rr_ptr = 0, pend_valid = 0, pend_src = 0, mask = 0.
  - Reset wins over en_i and flush_i.
- Stage A (grant), combinational from registered state:
  - eligible[k] = !src_empty_i[k] && !mask[k] && en_i && !flush_i.
  - Grant goes to the first eligible k, searching from rr_ptr upward with wrap at N_SRC-1 -> 0.
  - src_rd_o = one-hot(grant) if any source is eligible, else 0.
  - At most one pop per cycle.
- Stage A register update on posedge, when a grant occurs:
  - pend_valid <= 1, pend_src <= grant.
  - rr_ptr <= (grant + 1) mod N_SRC.
  - mask <= one-hot(grant).
  - With no grant: pend_valid <= 0, mask <= 0, rr_ptr holds.
- Back-off mask: a FIFO's empty flag lags its pop by one cycle, so a source granted in cycle N is ineligible in cycle N+1. A lone active source is therefore serviced at most every other cycle.
- Stage B (broadcast) on posedge:
  - If pend_valid && !flush_i: cdb_valid_o <= 1, cdb_data_o <= src_data_i[pend_src], cdb_src_o <= pend_src.
  - Otherwise cdb_valid_o <= 0; cdb_data_o and cdb_src_o hold.
- Latency: a pop in cycle N puts the result on the CDB in cycle N+2 (data lands in the FIFO output register at N+1 and is captured at the N+1 -> N+2 edge).
- flush_i = 1 for a cycle:
  - No pop is issued that cycle.
  - pend_valid <= 0, and the entry popped in the prior cycle is discarded, never broadcast.
  - cdb_valid_o <= 0 on the next edge.
  - rr_ptr is unchanged.
- en_i = 0:
  - No pops are issued.
  - pend_valid, mask, rr_ptr and the CDB outputs hold their values.
  - An already-pending entry stays pending and is broadcast on the first edge with en_i = 1.
- Simultaneous flush_i and en_i = 0: flush takes priority and clears pend_valid and cdb_valid_o.
- Wrap-around: with rr_ptr = N_SRC-1 and only source 0 eligible, the grant goes to 0 and rr_ptr becomes 1.
- No back-pressure: CDB consumers always accept, and each cdb_valid_o pulse lasts exactly one cycle per entry.

Decomposition:
- Shared package rv_pkg holds:
  - cdb_struct_t (tag [ROB_IDX_W-1:0], value [31:0], exc [3:0]).
  - ROB_IDX_W.
  - Source-index constants SRC_ALU, SRC_MUL, SRC_LSU, SRC_BR.
- One sub-module, rr_picker: combinational round-robin priority encoder.
  - Inputs: req[N_SRC], ptr[PTR_W].
  - Outputs: gnt_onehot[N_SRC], gnt_idx[PTR_W], any.
  - The arbiter instantiates it once.

Test Plan:
- Reset then idle: rst_n = 0 for 2 cycles, all src_empty_i = 1 -> src_rd_o = 0 and cdb_valid_o = 0 every cycle; rr_ptr = 0.
- Single source: FIFO 2 holds tags 5, 6, 7 -> pops at cycles N, N+2, N+4; CDB shows tags 5, 6, 7 at N+2, N+4, N+6 with cdb_src_o = 2.
- All four FIFOs non-empty from cycle 0 -> grants 0, 1, 2, 3, 0, ... one per cycle; cdb_src_o sequence 0, 1, 2, 3 starting at cycle 2.
- Wrap: rr_ptr = 3, only FIFO 0 and FIFO 3 non-empty -> grant 3, then 0 (3 is masked), then 3 again.
- Flush: pop FIFO 1 (tag 9) at cycle N, flush_i = 1 at N+1 -> tag 9 never appears on the CDB, cdb_valid_o = 0 at N+2, no pop at N+1.
- Stall: en_i = 0 for 3 cycles with a pending pop -> src_rd_o = 0 and the pending tag is broadcast exactly once, on the first edge with en_i = 1.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared core types: CDB payload and result-source indices.
// Imported by the CDB arbiter and its round-robin picker.
package rv_pkg;

  localparam int ROB_IDX_W = 6;

  localparam int SRC_ALU = 0;
  localparam int SRC_MUL = 1;
  localparam int SRC_LSU = 2;
  localparam int SRC_BR  = 3;

  typedef struct packed {
    logic [ROB_IDX_W-1:0] tag;
    logic [31:0]          value;
    logic [3:0]           exc;
  } cdb_struct_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin priority encoder: first set req bit at or above ptr.
// Ports: req, ptr in; gnt_onehot, gnt_idx, any out.
module rr_picker #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt_onehot,
  output logic [W-1:0] gnt_idx,
  output logic         any
);

  int k;

  // Walk offsets from farthest to nearest so the
  // nearest requester (from ptr) overwrites last.
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    k          = 0;
    for (int i = N - 1; i >= 0; i--) begin
      k = (int'(ptr) + i) % N;
      if (req[k]) begin
        gnt_onehot    = '0;
        gnt_onehot[k] = 1'b1;
        gnt_idx       = W'(k);
        any           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Pops per-FU result FIFOs round-robin, broadcasts one result/cycle.
// Ports: clk, rst_n, en_i, flush_i, src_* FIFO side, cdb_* bus side.
module cdb_arbiter
  import rv_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int PTR_W = $clog2(N_SRC)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              flush_i,
  input  logic [N_SRC-1:0]  src_empty_i,
  output logic [N_SRC-1:0]  src_rd_o,
  input  cdb_struct_t       src_data_i [N_SRC],
  output logic              cdb_valid_o,
  output cdb_struct_t       cdb_data_o,
  output logic [PTR_W-1:0]  cdb_src_o
);

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] pend_src;
  logic             pend_valid;
  logic [N_SRC-1:0] mask;

  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] gnt_onehot;
  logic [PTR_W-1:0] gnt_idx;
  logic             any;
  logic [PTR_W-1:0] ptr_nxt;

  // mask: the FIFO empty flag lags its pop by a cycle,
  // so last cycle's winner sits out one round.
  assign eligible = ~src_empty_i & ~mask
                  & {N_SRC{en_i & ~flush_i & rst_n}};

  rr_picker #(
    .N (N_SRC),
    .W (PTR_W)
  ) u_pick (
    .req        (eligible),
    .ptr        (rr_ptr),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (any)
  );

  assign src_rd_o = gnt_onehot;

  assign ptr_nxt = (gnt_idx == PTR_W'(N_SRC - 1))
                 ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      pend_src    <= '0;
      pend_valid  <= 1'b0;
      mask        <= '0;
      cdb_valid_o <= 1'b0;
      cdb_data_o  <= '0;
      cdb_src_o   <= '0;
    end else if (flush_i) begin
      pend_valid  <= 1'b0;
      mask        <= '0;
      cdb_valid_o <= 1'b0;
    end else if (en_i) begin
      cdb_valid_o <= pend_valid;
      if (pend_valid) begin
        cdb_data_o <= src_data_i[pend_src];
        cdb_src_o  <= pend_src;
      end
      pend_valid <= any;
      if (any) begin
        pend_src <= gnt_idx;
        rr_ptr   <= ptr_nxt;
        mask     <= gnt_onehot;
      end else begin
        mask <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter with queue-based FIFO model.
// Directed scenarios followed by randomized traffic.
module tb_cdb_arbiter;
  import rv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_i;
  logic        flush_i;
  logic [3:0]  src_empty_i;
  logic [3:0]  src_rd_o;
  cdb_struct_t src_data_i [4];
  logic        cdb_valid_o;
  cdb_struct_t cdb_data_o;
  logic [1:0]  cdb_src_o;

  always #5 clk = ~clk;

  cdb_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (en_i),
    .flush_i     (flush_i),
    .src_empty_i (src_empty_i),
    .src_rd_o    (src_rd_o),
    .src_data_i  (src_data_i),
    .cdb_valid_o (cdb_valid_o),
    .cdb_data_o  (cdb_data_o),
    .cdb_src_o   (cdb_src_o)
  );

  // FIFO models: registered read data, registered empty flag.
  cdb_struct_t fq [4][$];
  cdb_struct_t data_reg [4];
  logic [3:0]  empty_r = 4'hF;

  initial for (int k = 0; k < 4; k++) data_reg[k] = '0;

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (src_rd_o[k] && fq[k].size() != 0)
        data_reg[k] <= fq[k].pop_front();
      empty_r[k] <= (fq[k].size() == 0);
    end
  end

  assign src_empty_i = empty_r;
  always_comb for (int k = 0; k < 4; k++) src_data_i[k] = data_reg[k];

  // Reference model state
  int          m_ptr;
  bit          m_pv;
  int          m_ps;
  cdb_struct_t m_pd;
  bit [3:0]    m_mask;
  bit          m_cv;
  cdb_struct_t m_cd;
  int          m_cs;

  int total = 0;
  int bad = 0;
  int seen [$];
  logic [3:0] last_rd;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input int k, input int t);
    cdb_struct_t e;
    e.tag   = ROB_IDX_W'(t);
    e.value = $urandom;
    e.exc   = 4'($urandom_range(15));
    fq[k].push_back(e);
  endtask

  task automatic step(input bit rst, input bit en, input bit fl);
    int g;
    cdb_struct_t front;
    rst_n   = rst;
    en_i    = en;
    flush_i = fl;
    g = -1;
    if (rst && en && !fl)
      for (int i = 0; i < 4; i++) begin
        int k;
        k = (m_ptr + i) % 4;
        if (g < 0 && !empty_r[k] && !m_mask[k]) g = k;
      end
    front = (g >= 0) ? fq[g][0] : '0;
    @(negedge clk);
    chk("src_rd", 64'(src_rd_o), (g >= 0) ? 64'(1 << g) : 64'd0);
    chk("cdb_valid", 64'(cdb_valid_o), 64'(m_cv));
    chk("cdb_data", 64'(cdb_data_o), 64'(m_cd));
    chk("cdb_src", 64'(cdb_src_o), 64'(m_cs));
    last_rd = src_rd_o;
    if (cdb_valid_o) seen.push_back(int'(cdb_data_o.tag));
    @(posedge clk);
    if (!rst) begin
      m_ptr = 0; m_pv = 0; m_ps = 0; m_pd = '0;
      m_mask = '0; m_cv = 0; m_cd = '0; m_cs = 0;
    end else if (fl) begin
      m_pv = 0; m_mask = '0; m_cv = 0;
    end else if (en) begin
      m_cv = m_pv;
      if (m_pv) begin m_cd = m_pd; m_cs = m_ps; end
      if (g >= 0) begin
        m_pv = 1; m_ps = g; m_pd = front;
        m_ptr = (g + 1) % 4;
        m_mask = 4'(1 << g);
      end else begin
        m_pv = 0; m_mask = '0;
      end
    end
    #1;
  endtask

  function automatic int count_tag(input int t);
    int n = 0;
    foreach (seen[i]) if (seen[i] == t) n++;
    return n;
  endfunction

  initial begin
    int n;
    m_ptr = 0; m_pv = 0; m_ps = 0; m_pd = '0;
    m_mask = '0; m_cv = 0; m_cd = '0; m_cs = 0;
    rst_n = 0; en_i = 1; flush_i = 0;
    #1;
    // reset then idle
    step(0, 1, 0);
    step(0, 1, 0);
    repeat (3) step(1, 1, 0);

    // single source: LSU holds tags 5,6,7
    seen.delete();
    push(SRC_LSU, 5); push(SRC_LSU, 6); push(SRC_LSU, 7);
    repeat (10) step(1, 1, 0);
    chk("single_cnt", 64'(seen.size()), 64'd3);
    if (seen.size() == 3) begin
      chk("single_t0", 64'(seen[0]), 64'd5);
      chk("single_t1", 64'(seen[1]), 64'd6);
      chk("single_t2", 64'(seen[2]), 64'd7);
    end

    // wrap: ptr now 3, only FIFO 0 and 3 busy
    push(SRC_ALU, 20); push(SRC_ALU, 21);
    push(SRC_BR, 30); push(SRC_BR, 31);
    repeat (10) step(1, 1, 0);

    // all four busy
    for (int k = 0; k < 4; k++) begin
      push(k, 40 + k); push(k, 44 + k);
    end
    repeat (14) step(1, 1, 0);

    // flush kills the in-flight pop of tag 9
    seen.delete();
    push(SRC_MUL, 9);
    n = 0;
    do begin step(1, 1, 0); n++; end
    while (!last_rd[SRC_MUL] && n < 8);
    chk("flush_pop_seen", 64'(last_rd[SRC_MUL]), 64'd1);
    step(1, 1, 1);
    repeat (4) step(1, 1, 0);
    chk("flush_tag9", 64'(count_tag(9)), 64'd0);

    // stall with a pending entry
    seen.delete();
    push(SRC_ALU, 12);
    n = 0;
    do begin step(1, 1, 0); n++; end
    while (!last_rd[SRC_ALU] && n < 8);
    chk("stall_pop_seen", 64'(last_rd[SRC_ALU]), 64'd1);
    repeat (3) step(1, 0, 0);
    repeat (4) step(1, 1, 0);
    chk("stall_tag12", 64'(count_tag(12)), 64'd1);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      bit r, e, f;
      for (int k = 0; k < 4; k++)
        if ($urandom_range(99) < 30 && fq[k].size() < 6)
          push(k, $urandom_range(63));
      r = ($urandom_range(199) != 0);
      e = ($urandom_range(9) != 0);
      f = ($urandom_range(19) == 0);
      step(r, e, f);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
